// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the iterative binary-to-BCD converter:
//   - state_e      : converter FSM state encoding (2 bits)
//   - BCD_DIGIT_W  : width of one packed BCD digit
//   - digits_needed: number of decimal digits needed to hold 2^bin_w - 1,
//                    used to reject an undersized DIGITS at elaboration
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W = 4;

    // Decimal digit count of the largest unsigned value of bin_w bits.
    function automatic int digits_needed(input int bin_w);
        longint unsigned max_val;
        int              n;
        max_val = (longint'(1) << bin_w) - 1;
        n       = 1;
        while (max_val >= 10) begin
            max_val = max_val / 10;
            n       = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for one BCD digit: adds 3 when the digit is >= 5
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit_i : 4-bit BCD digit before correction
//   digit_o : 4-bit corrected digit (no carry out; cannot overflow for 0..9)
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative shift-and-add-3 converter, one input bit per clock.
// A conversion takes BIN_W+2 cycles from handshake to the next possible
// handshake; bcd_out/blank are registered and hold between results.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high reset
//   in_valid  : bin_in is valid this cycle
//   in_ready  : converter idle and able to accept
//   bin_in    : unsigned binary input, BIN_W bits
//   out_valid : one-cycle strobe, bcd_out/blank newly updated
//   bcd_out   : packed BCD, digit 0 (ones) in bits [3:0]
//   blank     : leading-zero mask, blank[i]=1 when digit i and above are 0
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BIN_W-1:0]            bin_in,
    output logic                        out_valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]           blank
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    // Reset/idle mask: every digit except the ones digit is blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

    // Elaboration-time parameter checks.
    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin2bcd_seq: BIN_W=%0d outside 1..32", BIN_W);
    end
    if (DIGITS < digits_needed(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    state_e              state_q;
    logic [WORK_W-1:0]   work_q;       // {bcd, bin}
    logic [CNT_W-1:0]    cnt_q;
    logic [BCD_W-1:0]    bcd_out_q;
    logic [DIGITS-1:0]   blank_q;
    logic                out_valid_q;

    logic [BCD_W-1:0]    adj_bcd;
    logic [WORK_W-1:0]   work_shift_d;
    logic [DIGITS-1:0]   blank_d;

    // All digits are corrected in parallel from the current register value.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_q[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .digit_o (adj_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // Corrected digits then a 1-bit left shift: bin MSB enters digit-0 LSB.
    assign work_shift_d = {adj_bcd, work_q[BIN_W-1:0]} << 1;

    // Leading-zero mask, built from the top digit downwards.
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_ones
            assign blank_d[i] = 1'b0;
        end else if (i == DIGITS-1) begin : g_top
            assign blank_d[i] = (work_q[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
        end else begin : g_mid
            assign blank_d[i] = (work_q[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0)
                                && blank_d[i+1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            bcd_out_q   <= '0;
            blank_q     <= BLANK_RST;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q  <= {{BCD_W{1'b0}}, bin_in};
                        cnt_q   <= CNT_W'(BIN_W);
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_q <= work_shift_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_out_q   <= work_q[WORK_W-1 -: BCD_W];
                    blank_q     <= blank_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_out_q;
    assign blank     = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed self-checking bench for bin2bcd_seq with BIN_W=14, DIGITS=5.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 5;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .blank     (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; steps falling edges until out_valid is seen
    // (bounded). lat counts falling edges stepped; busy_ok drops if in_ready
    // is seen high before the strobe.
    task automatic wait_strobe(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    // One complete conversion with expected latency BIN_W+1 edges.
    task automatic run_conv(input logic [BIN_W-1:0] val, input logic [19:0] exp_bcd,
                            input logic [4:0] exp_blank, input string tag);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        bin_in   = val;
        @(negedge clk);
        in_valid = 1'b0;
        wait_strobe(lat, busy_ok);
        check({tag, " latency"}, 32'(lat), 32'd15);
        check({tag, " busy"}, 32'(busy_ok), 32'd1);
        check({tag, " bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({tag, " blank"}, 32'(blank), 32'(exp_blank));
        @(negedge clk);
        check({tag, " single strobe"}, 32'(out_valid), 32'd0);
        check({tag, " idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int   lat;
        int   t1;
        logic busy_ok;
        logic seen;

        reset    = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst bcd", 32'(bcd_out), 32'h00000);
        check("rst blank", 32'(blank), 32'b11110);

        // Single conversions, including zero and the maximum input.
        run_conv(14'd0,     20'h00000, 5'b11110, "zero");
        run_conv(14'd127,   20'h00127, 5'b11000, "v127");
        run_conv(14'd9999,  20'h09999, 5'b10000, "v9999");
        run_conv(14'd16383, 20'h16383, 5'b00000, "max");

        // Back-to-back with in_valid held high: 1000 then 42.
        @(negedge clk);
        in_valid = 1'b1;
        bin_in   = 14'd1000;
        @(negedge clk);
        wait_strobe(lat, busy_ok);
        t1 = cyc;
        check("b2b1 latency", 32'(lat), 32'd15);
        check("b2b1 bcd", 32'(bcd_out), 32'h01000);
        check("b2b1 blank", 32'(blank), 32'b10000);
        check("b2b1 ready", 32'(in_ready), 32'd1);
        bin_in = 14'd42;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b2 taken", 32'(in_ready), 32'd0);
        wait_strobe(lat, busy_ok);
        check("b2b2 busy", 32'(busy_ok), 32'd1);
        check("b2b gap", 32'(cyc - t1), 32'd16);
        check("b2b2 bcd", 32'(bcd_out), 32'h00042);
        check("b2b2 blank", 32'(blank), 32'b11100);
        @(negedge clk);

        // in_valid during SHIFT is ignored.
        in_valid = 1'b1;
        bin_in   = 14'd321;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        bin_in   = 14'd555;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        wait_strobe(lat, busy_ok);
        check("ignore latency", 32'(lat), 32'd10);
        check("ignore busy", 32'(busy_ok), 32'd1);
        check("ignore bcd", 32'(bcd_out), 32'h00321);
        check("ignore blank", 32'(blank), 32'b11000);
        @(negedge clk);
        check("ignore no restart", 32'(in_ready), 32'd1);

        // Reset five cycles into a conversion of 8191.
        in_valid = 1'b1;
        bin_in   = 14'd8191;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort bcd", 32'(bcd_out), 32'h00000);
        check("abort blank", 32'(blank), 32'b11110);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        check("abort no strobe", 32'(seen), 32'd0);
        run_conv(14'd8191, 20'h08191, 5'b10000, "v8191");

        // Reset coincident with a handshake wins.
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        bin_in   = 14'd77;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst+hs in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        check("rst+hs no strobe", 32'(seen), 32'd0);
        check("rst+hs bcd", 32'(bcd_out), 32'h00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
